// File: rtl/lifo_rev_ctl.sv
// lifo_rev_ctl: initiator-side controller for a push/pop LIFO.
// Valid/ready on both streams: a word moves on a cycle where valid and ready
// are both high at the rising edge; valid never depends on ready, and a
// producer holds its word stable while valid is high and ready is low.
// Words of an input packet are pushed into the LIFO as they arrive. Once the
// last word is in, the LIFO is drained one word at a time and the packet leaves
// word-reversed. Words beyond DEPTH are dropped and raise a sticky ovf flag.
module lifo_rev_ctl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             lifo_push,
    output logic             lifo_pop,
    output logic [WIDTH-1:0] lifo_din,
    input  logic [WIDTH-1:0] lifo_dout,
    input  logic             lifo_empty,
    input  logic             lifo_full,
    output logic             ovf
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    // FILL: storing words; DROP: discarding overflow words until last;
    // POP: one-cycle pop strobe; CAPT: LIFO output is valid, capture it;
    // SEND: present the captured word until the sink takes it.
    typedef enum logic [2:0] {
        FILL = 3'd0,
        DROP = 3'd1,
        POP  = 3'd2,
        CAPT = 3'd3,
        SEND = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          in_hs;

    // Input is accepted only while filling with room left, or while dropping.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            FILL:    in_ready = !lifo_full && (cnt < CNT_MAX);
            DROP:    in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    assign in_hs     = in_valid && in_ready;
    assign lifo_push = (state == FILL) && in_hs;
    assign lifo_din  = lifo_push ? in_data : '0;
    assign lifo_pop  = (state == POP);

    // Main controller: word counting, overflow tracking and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_hs) begin
                        // in_ready guarantees cnt < DEPTH here, so no wrap.
                        cnt <= cnt + 1'b1;
                        if (in_last) begin
                            state <= POP;
                        end else if (cnt == CNT_LAST) begin
                            state <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (in_valid) begin
                        ovf <= 1'b1;
                        if (in_last) begin
                            state <= POP;
                        end
                    end
                end
                POP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                    state <= CAPT;
                end
                CAPT: begin
                    // lifo_dout is valid the cycle after the pop strobe.
                    out_data  <= lifo_dout;
                    out_valid <= 1'b1;
                    out_last  <= (cnt == '0);
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= out_last ? FILL : POP;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    // Popping an empty LIFO means the LIFO and this controller disagree on
    // occupancy; the packet still completes, but flag it in simulation.
    pop_not_empty_a: assert property (@(posedge clk) disable iff (!rst_n)
        lifo_pop |-> !lifo_empty);

endmodule

// File: tb/tb_lifo_rev_ctl.sv
// Bench for lifo_rev_ctl: behavioural LIFO partner, table-driven packets,
// scoreboard of reversed words, plus backpressure and mid-drain reset cases.
module tb_lifo_rev_ctl;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int MAXW  = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT ----------------
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready = 1'b1;
  logic             lifo_push, lifo_pop;
  logic [WIDTH-1:0] lifo_din;
  logic [WIDTH-1:0] lifo_dout;
  logic             lifo_empty, lifo_full;
  logic             ovf;

  lifo_rev_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .lifo_push(lifo_push), .lifo_pop(lifo_pop), .lifo_din(lifo_din),
    .lifo_dout(lifo_dout), .lifo_empty(lifo_empty), .lifo_full(lifo_full),
    .ovf(ovf)
  );

  // ---------------- behavioural LIFO (same reset) ----------------
  logic [WIDTH-1:0] mem [DEPTH];
  int sp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= 0;
      lifo_dout <= '0;
    end else if (lifo_push && sp < DEPTH) begin
      mem[sp] <= lifo_din;
      sp <= sp + 1;
    end else if (lifo_pop && sp > 0) begin
      lifo_dout <= mem[sp-1];
      sp <= sp - 1;
    end
  end
  assign lifo_empty = (sp == 0);
  assign lifo_full  = (sp == DEPTH);

  // ---------------- scoreboard / counters ----------------
  logic [WIDTH:0] exp_q[$];   // {last, data}
  int n_pass = 0;
  int n_total = 0;
  logic ovf_model = 1'b0;
  bit lat_pending = 0;
  int hs_edge = 0;
  bit chk_period = 0;
  int last_rise = -1;
  logic ov_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
  endtask

  // Output monitor: compare every accepted output word, latency and period.
  always @(negedge clk) begin
    logic [WIDTH:0] e;
    if (rst_n) begin
      if (lifo_pop) begin
        check("pop_lifo_nonempty", {31'd0, lifo_empty}, 32'd0);
        check("push_pop_excl", {31'd0, lifo_push}, 32'd0);
      end
      if (lat_pending && out_valid) begin
        check("first_out_latency", cyc - hs_edge, 2);
        lat_pending = 0;
      end
      if (out_valid && !ov_d) begin
        if (chk_period && last_rise >= 0) check("word_period", cyc - last_rise, 3);
        last_rise = cyc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail("unexpected_output");
        else begin
          e = exp_q.pop_front();
          check("out_data", {16'd0, out_data}, {16'd0, e[WIDTH-1:0]});
          check("out_last", {31'd0, out_last}, {31'd0, e[WIDTH]});
        end
      end
      ov_d = out_valid;
    end else begin
      ov_d = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_packet(input logic [WIDTH-1:0] w[MAXW], input int len);
    logic [WIDTH-1:0] kept[$];
    bit got;
    logic first_ready;
    last_rise = -1;
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      in_last  = (i == len - 1);
      got = 0;
      first_ready = 1'b0;
      for (int t = 0; t < 60; t++) begin
        @(negedge clk);
        if (t == 0) first_ready = in_ready;
        if (in_ready) begin
          got = 1;
          break;
        end
      end
      if (!got) begin
        fail("in_ready_timeout");
        in_valid = 1'b0;
        in_last = 1'b0;
        return;
      end
      if (i >= DEPTH) check("in_ready_during_drop", {31'd0, first_ready}, 32'd1);
      if (i < DEPTH) kept.push_back(w[i]);
      else ovf_model = 1'b1;
      if (in_last) begin
        for (int k = kept.size() - 1; k >= 0; k--)
          exp_q.push_back({(k == 0) ? 1'b1 : 1'b0, kept[k]});
        hs_edge = cyc + 1;
        lat_pending = 1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("ovf_after_word", {31'd0, ovf}, {31'd0, ovf_model});
      if (i == DEPTH - 1) check("lifo_full_at_depth", {31'd0, lifo_full}, 32'd1);
    end
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1;
        break;
      end
    end
    if (!done) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    ovf_model = 1'b0;
    lat_pending = 0;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  // ---------------- test vectors ----------------
  typedef struct {
    int               len;
    logic [WIDTH-1:0] w [MAXW];
    logic             exp_ovf;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs [NV];

  task automatic set_vec(input int idx, input int len, input logic [WIDTH-1:0] base,
                         input logic [WIDTH-1:0] step, input logic exp_ovf);
    vecs[idx].len = len;
    vecs[idx].exp_ovf = exp_ovf;
    for (int i = 0; i < MAXW; i++) vecs[idx].w[i] = base + WIDTH'(i) * step;
  endtask

  initial begin
    logic [WIDTH-1:0] hold_d;
    logic hold_l;
    logic [WIDTH-1:0] pw [MAXW];
    bit got;

    // Reset and idle outputs.
    do_reset();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_lifo_push", {31'd0, lifo_push}, 32'd0);
    check("rst_lifo_pop", {31'd0, lifo_pop}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_last", {31'd0, out_last}, 32'd0);

    // Table: reversal, full depth, single word, random length, overflow.
    set_vec(0, 3, 16'h1111, 16'h1111, 1'b0);
    set_vec(1, 4, 16'hA000, 16'h0001, 1'b0);
    set_vec(2, 1, 16'h5A5A, 16'h0000, 1'b0);
    set_vec(3, $urandom_range(1, DEPTH), 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < MAXW; i++) vecs[3].w[i] = WIDTH'($urandom_range(0, 16'hFFFF));
    set_vec(4, 6, 16'hB000, 16'h0001, 1'b1);

    chk_period = 1;
    out_ready = 1'b1;
    for (int v = 0; v < NV; v++) begin
      send_packet(vecs[v].w, vecs[v].len);
      wait_drain();
      check("pkt_ovf", {31'd0, ovf}, {31'd0, vecs[v].exp_ovf});
      check("pkt_idle_in_ready", {31'd0, in_ready}, 32'd1);
    end

    // Backpressure: first output held for 5 cycles.
    do_reset();
    chk_period = 0;
    out_ready = 1'b0;
    for (int i = 0; i < MAXW; i++) pw[i] = 16'hD001 + WIDTH'(i);
    send_packet(pw, 3);
    got = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1;
        break;
      end
    end
    if (!got) fail("bp_out_valid_timeout");
    hold_d = out_data;
    hold_l = out_last;
    check("bp_first_word", {16'd0, hold_d}, 32'h0000D003);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("bp_data_stable", {16'd0, out_data}, {16'd0, hold_d});
      check("bp_last_stable", {31'd0, out_last}, {31'd0, hold_l});
      check("bp_valid_held", {31'd0, out_valid}, 32'd1);
      check("bp_no_pop", {31'd0, lifo_pop}, 32'd0);
      check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();

    // Reset mid-drain after one of three outputs.
    chk_period = 1;
    for (int i = 0; i < MAXW; i++) pw[i] = 16'hE001 + WIDTH'(i);
    send_packet(pw, 3);
    got = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (exp_q.size() == 2) begin
        got = 1;
        break;
      end
    end
    if (!got) fail("mid_drain_first_word_timeout");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    ovf_model = 1'b0;
    lat_pending = 0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_data", {16'd0, out_data}, 32'd0);
    check("mid_rst_out_last", {31'd0, out_last}, 32'd0);
    check("mid_rst_pop", {31'd0, lifo_pop}, 32'd0);
    check("mid_rst_push", {31'd0, lifo_push}, 32'd0);
    check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    pw[0] = 16'hC001;
    send_packet(pw, 1);
    wait_drain();
    check("post_rst_ovf", {31'd0, ovf}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

endmodule

// File: doc/lifo_rev_ctl.md
Name: lifo_rev_ctl

Overview:
- Initiator-side controller for the team's push/pop LIFO (lifo_ctl): drives push, pop and data_in, and consumes data_out, empty and full.
- Accepts a packet on a valid/ready input stream and pushes each word into the LIFO.
- On the last word it pops the LIFO and emits the packet word-reversed on a valid/ready output stream.
- Sits between a packet source and sink, with one lifo_ctl instance of matching WIDTH/DEPTH.

Parameters:
- WIDTH, 16, data word width; must equal the LIFO WIDTH.
- DEPTH, 4, maximum packet length in words; must equal the LIFO DEPTH.
- CW, $clog2(DEPTH+1), local; width of the internal word counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset; clears all state immediately.
- in_valid  in  1  input word valid.
- in_data  in  WIDTH  input word.
- in_last  in  1  marks the final word of a packet.
- in_ready  out  1  controller accepts in_data this cycle.
- out_valid  out  1  output word valid.
- out_data  out  WIDTH  output word (reversed order).
- out_last  out  1  marks the final output word of the packet.
- out_ready  in  1  sink accepts out_data this cycle.
- lifo_push  out  1  to LIFO push.
- lifo_pop  out  1  to LIFO pop.
- lifo_din  out  WIDTH  to LIFO data_in.
- lifo_dout  in  WIDTH  from LIFO data_out; valid the cycle after lifo_pop.
- lifo_empty  in  1  from LIFO empty.
- lifo_full  in  1  from LIFO full.
- ovf  out  1  sticky: a packet exceeded DEPTH words; cleared only by reset.

Behaviour:
- Reset state: state = FILL, cnt = 0. All outputs 0 except in_ready, which is 1 once FILL is active and lifo_full = 0.
- The LIFO must share the same reset event so that it is empty when rst_n releases.
- FSM states: FILL, DROP, POP, CAPT, SEND.
- FILL: in_ready = !lifo_full && cnt < DEPTH.
  - Handshake (in_valid && in_ready) asserts lifo_push combinationally with lifo_din = in_data and increments cnt.
  - Accepted word with in_last = 1 -> POP.
  - Accepted word with in_last = 0 and cnt becoming DEPTH -> DROP.
- DROP: in_ready = 1; incoming words are discarded with no push.
  - Any discarded word sets ovf = 1.
  - A word with in_last = 1 -> POP.
  - The stored DEPTH words are still emitted reversed (truncated packet).
- POP: lifo_pop = 1 for exactly one cycle; cnt decrements; -> CAPT.
- CAPT: register lifo_dout into out_data; out_valid <= 1; out_last <= (cnt == 0); -> SEND.
- SEND: out_data, out_valid and out_last are held stable until out_ready = 1.
  - On handshake: out_valid <= 0; if out_last -> FILL, else -> POP.
- Latency and throughput:
  - First output word is valid 2 cycles after the in_last handshake.
  - Steady state is 3 cycles per output word with out_ready held high.
- Push and pop are never asserted in the same cycle; in_ready = 0 in POP, CAPT and SEND.
- Cross-check: lifo_empty = 1 while in POP signals a protocol error. The block still completes the packet; ovf is unaffected. The bench flags this as a failure.
- cnt never wraps: it saturates at DEPTH in FILL and stops at 0 after the last pop.
- Single-word packet: FILL -> POP -> CAPT -> SEND, with out_last = 1 on that word.
- Reset mid-packet: state aborts immediately, outputs clear, the partial packet is lost, and ovf clears.
- out_ready asserted while out_valid = 0 has no effect.
- in_valid while in_ready = 0 is ignored; the source holds the word.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles, release -> out_valid = 0, lifo_push = lifo_pop = 0, ovf = 0, in_ready = 1.
- Packet reversal:
  - Stimulus: push 0x1111, 0x2222, 0x3333 (last on 0x3333), out_ready = 1.
  - Required: out_data 0x3333, 0x2222, 0x1111; out_last only on 0x1111; first out_valid 2 cycles after the last input handshake.
- Full-depth packet: 4 words 0xA000..0xA003 with last on the 4th -> 4 reversed words, ovf = 0, lifo_full seen high after the 4th push.
- Overflow:
  - Stimulus: 6 words 0xB000..0xB005, last on 0xB005.
  - Required: in_ready stays 1; ovf = 1 after 0xB004; output 0xB003..0xB000 with last on 0xB000.
- Backpressure: out_ready = 0 for 5 cycles during SEND -> out_data and out_last stable; no lifo_pop; in_ready = 0.
- Reset mid-drain: assert rst_n = 0 after 1 of 3 outputs -> all outputs 0 within the same cycle; a new packet 0xC001 (single, last) emits 0xC001 with out_last = 1.
